fetch_unit: RTL
===============

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter: RESET_PC, default 32'h1eceb000, meaning PC loaded on reset.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 imem_addr  output  32  fetch address, word-aligned.
REQ-005 imem_rmask  output  4  read strobe: 4'b1111 on issue cycle, else 4'b0000.
REQ-006 imem_rdata  input  32  instruction returned by memory.
REQ-007 imem_resp  input  1  one-cycle response-valid strobe.
REQ-008 bp_taken, bp_target[31:0], bp_pattern[3:0], bp_counter[1:0]  input  predictor lookup for current imem_addr, valid in the same cycle.
REQ-009 queue_full  input  1  instruction queue cannot accept a write.
REQ-010 write_en  output  1  queue write strobe.
REQ-011 write_data, write_pc  output  32 each  instruction and its PC.
REQ-012 branch_pattern[3:0], saturating_counter[1:0], pc_target_predict[31:0]  output  prediction metadata paired with write_data.
REQ-013 flush  input  1  redirect request from backend.
REQ-014 flush_pc  input  32  redirect target; bits [1:0] forced to 0.
REQ-015 fetch_count  output  32  number of completed queue writes since reset.

Function
REQ-016 FSM states: REQ (issue), WAIT (request outstanding), HOLD (instruction buffered, queue full), DRAIN (discard stale response).
REQ-017 At most one memory request shall be outstanding; imem_addr shall hold the PC register value in all states.
REQ-018 REQ, flush=0: imem_rmask=4'b1111 for one cycle; latch bp_pattern, bp_counter and next_pc = bp_taken ? bp_target : pc+4 into metadata registers; go to WAIT.
REQ-019 WAIT, imem_resp=1, queue_full=0, flush=0: write_en=1 in the same cycle, with write_data=imem_rdata, write_pc=pc and latched metadata (pc_target_predict=next_pc); pc <= next_pc; go to REQ.
REQ-020 WAIT, imem_resp=1, queue_full=1, flush=0: capture imem_rdata into the hold register; write_en=0; go to HOLD.
REQ-021 HOLD, queue_full=0, flush=0: write_en=1 from the hold register and metadata; pc <= next_pc; go to REQ. HOLD with queue_full=1 stays in HOLD.
REQ-022 Minimum fetch-to-write latency: 2 cycles (REQ cycle, response in the following WAIT cycle); sustained throughput with a 1-cycle memory is one instruction per 2 cycles.
REQ-023 flush has priority over every other event; write_en=0 and imem_rmask=0 in any cycle with flush=1.
REQ-024 Flush in REQ: pc <= flush_pc; stay in REQ.
REQ-025 Flush in WAIT without imem_resp: pc <= flush_pc; go to DRAIN.
REQ-026 Flush in WAIT with imem_resp in the same cycle: discard the response; pc <= flush_pc; go to REQ.
REQ-027 Flush in HOLD: discard the buffered instruction; pc <= flush_pc; go to REQ.
REQ-028 DRAIN: no write_en. On imem_resp, discard the data and go to REQ. A flush in DRAIN updates pc and stays in DRAIN (or goes to REQ if imem_resp is in the same cycle).
REQ-029 imem_resp in REQ or HOLD shall be ignored.
REQ-030 fetch_count increments by 1 in each cycle with write_en=1 and wraps modulo 2^32.
REQ-031 PC arithmetic is 32-bit unsigned and wraps; pc+4 at 32'hfffffffc yields 32'h00000000.

Reset
REQ-032 rst=1: pc=RESET_PC, state=REQ, write_en=0, imem_rmask=0, fetch_count=0, hold and metadata registers=0.
REQ-033 Reset mid-request abandons the outstanding request; the first request after reset is issued in the first cycle with rst=0.

Verification
REQ-034 Reset, then memory with 1-cycle response and queue never full -> requests at 1eceb000, 1eceb004, 1eceb008; write_en every 2nd cycle; fetch_count=3 after the third write.
REQ-035 bp_taken=1, bp_target=1eceb100 at PC 1eceb000 -> write carries pc_target_predict=1eceb100; next imem_addr=1eceb100.
REQ-036 queue_full=1 when the response arrives, released after 3 cycles -> HOLD for 3 cycles with write_en=0, then one write with the original data and PC; no new request during HOLD.
REQ-037 flush (flush_pc=1eceb203) asserted in WAIT, response arriving 2 cycles later -> response discarded, no write_en, next request at 1eceb200.
REQ-038 flush in the same cycle as imem_resp and in HOLD -> no write; next imem_addr=flush_pc; fetch_count unchanged.
REQ-039 rst asserted during WAIT, followed by a stale imem_resp in the cycle after reset -> response ignored, imem_addr=1eceb000, write_en=0.

Source files
------------

// File: rtl/fetch_unit_if.sv
// Fetch unit bus bundle: instruction memory, branch predictor lookup,
// instruction queue write port and backend redirect.
interface fetch_unit_if;
  logic [31:0] imem_addr;
  logic [3:0]  imem_rmask;
  logic [31:0] imem_rdata;
  logic        imem_resp;
  logic        bp_taken;
  logic [31:0] bp_target;
  logic [3:0]  bp_pattern;
  logic [1:0]  bp_counter;
  logic        queue_full;
  logic        write_en;
  logic [31:0] write_data;
  logic [31:0] write_pc;
  logic [3:0]  branch_pattern;
  logic [1:0]  saturating_counter;
  logic [31:0] pc_target_predict;
  logic        flush;
  logic [31:0] flush_pc;
  logic [31:0] fetch_count;

  modport master (
    output imem_addr, imem_rmask, write_en, write_data, write_pc,
           branch_pattern, saturating_counter, pc_target_predict, fetch_count,
    input  imem_rdata, imem_resp, bp_taken, bp_target, bp_pattern, bp_counter,
           queue_full, flush, flush_pc
  );

  modport slave (
    input  imem_addr, imem_rmask, write_en, write_data, write_pc,
           branch_pattern, saturating_counter, pc_target_predict, fetch_count,
    output imem_rdata, imem_resp, bp_taken, bp_target, bp_pattern, bp_counter,
           queue_full, flush, flush_pc
  );
endinterface

// File: rtl/fetch_unit.sv
// Single-outstanding instruction fetch: issues one request, forwards the
// response (or buffers it while the queue is full) with its prediction metadata.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h1eceb000
) (
  input logic          clk,
  input logic          rst,
  fetch_unit_if.master bus
);
  localparam logic [1:0] S_REQ   = 2'd0;
  localparam logic [1:0] S_WAIT  = 2'd1;
  localparam logic [1:0] S_HOLD  = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] next_pc_q, next_pc_d;
  logic [31:0] hold_q, hold_d;
  logic [3:0]  pat_q, pat_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] count_q, count_d;
  logic [31:0] redirect_pc;
  logic        issue;
  logic        wr;

  assign redirect_pc = bus.flush_pc & 32'hffff_fffc;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    next_pc_d = next_pc_q;
    hold_d    = hold_q;
    pat_d     = pat_q;
    cnt_d     = cnt_q;
    issue     = 1'b0;
    wr        = 1'b0;
    // A flush wins over every other event in every state.
    case (state_q)
      S_REQ: begin
        if (bus.flush) begin
          pc_d = redirect_pc;
        end else begin
          issue     = 1'b1;
          pat_d     = bus.bp_pattern;
          cnt_d     = bus.bp_counter;
          next_pc_d = bus.bp_taken ? bus.bp_target : pc_q + 32'd4;
          state_d   = S_WAIT;
        end
      end
      S_WAIT: begin
        if (bus.flush) begin
          pc_d    = redirect_pc;
          state_d = bus.imem_resp ? S_REQ : S_DRAIN;
        end else if (bus.imem_resp) begin
          if (bus.queue_full) begin
            hold_d  = bus.imem_rdata;
            state_d = S_HOLD;
          end else begin
            wr      = 1'b1;
            pc_d    = next_pc_q;
            state_d = S_REQ;
          end
        end
      end
      S_HOLD: begin
        if (bus.flush) begin
          pc_d    = redirect_pc;
          state_d = S_REQ;
        end else if (!bus.queue_full) begin
          wr      = 1'b1;
          pc_d    = next_pc_q;
          state_d = S_REQ;
        end
      end
      default: begin
        if (bus.flush) pc_d = redirect_pc;
        if (bus.imem_resp) state_d = S_REQ;
      end
    endcase
    count_d = count_q + {31'd0, wr};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_REQ;
      pc_q      <= RESET_PC;
      next_pc_q <= 32'd0;
      hold_q    <= 32'd0;
      pat_q     <= 4'd0;
      cnt_q     <= 2'd0;
      count_q   <= 32'd0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      next_pc_q <= next_pc_d;
      hold_q    <= hold_d;
      pat_q     <= pat_d;
      cnt_q     <= cnt_d;
      count_q   <= count_d;
    end
  end

  assign bus.imem_addr          = pc_q;
  assign bus.imem_rmask         = (issue && !rst) ? 4'b1111 : 4'b0000;
  assign bus.write_en           = wr && !rst;
  assign bus.write_data         = (state_q == S_HOLD) ? hold_q : bus.imem_rdata;
  assign bus.write_pc           = pc_q;
  assign bus.branch_pattern     = pat_q;
  assign bus.saturating_counter = cnt_q;
  assign bus.pc_target_predict  = next_pc_q;
  assign bus.fetch_count        = count_q;
endmodule
